// File: rtl/blinker_pkg.sv
// Shared definitions for the blinker pipeline: dimmer state encoding,
// default widths and the step-divider counter width helper.
package blinker_pkg;

   // Dimmer state machine encoding.
   typedef enum logic [1:0] {
      OFF  = 2'd0,
      UP   = 2'd1,
      ON   = 2'd2,
      DOWN = 2'd3
   } dimmer_state_t;

   // Plain-vector aliases of the states for tools that dislike enum registers.
   localparam logic [1:0] S_OFF  = OFF;
   localparam logic [1:0] S_UP   = UP;
   localparam logic [1:0] S_ON   = ON;
   localparam logic [1:0] S_DOWN = DOWN;

   // Default widths.
   localparam int DEF_PWM_W    = 32'd8;
   localparam int DEF_STEP_DIV = 32'd4;

   // Width of a counter running 0..step_div-1 (at least one bit).
   function automatic int div_cnt_width(input int step_div);
      if (step_div > 32'd1) begin
         return $clog2(step_div);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/blinker_pwm_gen.sv
// PWM generator for the blinker dimmer: free-running period counter,
// period-boundary strobe, per-period duty latch and registered LED compare.
// The duty presented at a boundary governs the whole period that starts there.
module blinker_pwm_gen
   import blinker_pkg::*;
#(
   parameter int PWM_W = DEF_PWM_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [PWM_W-1:0] i_duty,
   output logic             o_boundary,
   output logic             o_led
);

   localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};
   localparam logic [PWM_W-1:0] CNT_ZERO = {PWM_W{1'b0}};
   localparam logic [PWM_W-1:0] CNT_ONE  = PWM_W'(32'd1);

   logic [PWM_W-1:0] r_pwm_cnt;
   logic [PWM_W-1:0] r_duty_q;
   logic             r_led;
   logic [PWM_W-1:0] w_duty_eff;
   logic             w_boundary;

   assign w_boundary = (r_pwm_cnt == CNT_ZERO);

   // Duty in force for the current count: the fresh value on the boundary cycle.
   always_comb begin
      w_duty_eff = r_duty_q;
      if (w_boundary) begin
         w_duty_eff = i_duty;
      end else begin
         w_duty_eff = r_duty_q;
      end
   end

   // Period counter, duty latch and LED compare register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pwm_cnt <= CNT_ZERO;
         r_duty_q  <= CNT_ZERO;
         r_led     <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + CNT_ONE;
         if (w_boundary) begin
            r_duty_q <= i_duty;
         end
         if (w_duty_eff == DUTY_MAX) begin
            r_led <= 1'b1;
         end else begin
            r_led <= (r_pwm_cnt < w_duty_eff);
         end
      end
   end

   assign o_boundary = w_boundary;
   assign o_led      = r_led;

endmodule

// File: rtl/blinker_dimmer.sv
// Blinker dimmer: turns each edge of the registered blink level into a
// linear brightness ramp rendered as PWM on the LED.
// Optional build macro BLINKER_GAMMA_EN: duty follows a squared (gamma)
// curve of the level instead of the level itself.
module blinker_dimmer
   import blinker_pkg::*;
#(
   parameter int PWM_W    = DEF_PWM_W,
   parameter int STEP_DIV = DEF_STEP_DIV
) (
   input  logic             system1000,
   input  logic             system1000_rst,
   input  logic             blink_i,
   output logic             led_o,
   output logic [PWM_W-1:0] level_o,
   output logic             busy_o
);

   localparam int               DIV_W    = div_cnt_width(STEP_DIV);
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 32'd1);
   localparam logic [PWM_W-1:0] LVL_MAX  = {PWM_W{1'b1}};
   localparam logic [PWM_W-1:0] LVL_ZERO = {PWM_W{1'b0}};
   localparam logic [PWM_W-1:0] LVL_ONE  = PWM_W'(32'd1);

   logic             r_blink_q;
   logic [DIV_W-1:0] r_div_cnt;
   logic [1:0]       r_state;
   logic [PWM_W-1:0] r_level;
   logic             r_busy;

   logic             w_boundary;
   logic             w_tick;
   logic             w_led;
   logic [1:0]       w_state_nxt;
   logic [PWM_W-1:0] w_level_nxt;
   logic [PWM_W-1:0] w_level_inc;
   logic [PWM_W-1:0] w_level_dec;
   logic [PWM_W-1:0] w_duty;

`ifdef BLINKER_GAMMA_EN
   // Gamma duty: level squared at double width, upper half kept; full level stays full.
   function automatic logic [PWM_W-1:0] f_duty(input logic [PWM_W-1:0] lvl);
      logic [2*PWM_W-1:0] sq;
      sq = {LVL_ZERO, lvl} * {LVL_ZERO, lvl};
      if (lvl == LVL_MAX) begin
         f_duty = LVL_MAX;
      end else begin
         f_duty = sq[2*PWM_W-1:PWM_W];
      end
   endfunction
`else
   // Linear duty: the level is the duty.
   function automatic logic [PWM_W-1:0] f_duty(input logic [PWM_W-1:0] lvl);
      f_duty = lvl;
   endfunction
`endif

   assign w_tick      = w_boundary && (r_div_cnt == DIV_LAST);
   assign w_level_inc = (r_level == LVL_MAX)  ? LVL_MAX  : (r_level + LVL_ONE);
   assign w_level_dec = (r_level == LVL_ZERO) ? LVL_ZERO : (r_level - LVL_ONE);
   assign w_duty      = f_duty(r_level);

   // Next state and level; a blink edge always wins over a step tick.
   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      case (r_state)
         S_OFF: begin
            if (r_blink_q) begin
               w_state_nxt = S_UP;
            end else begin
               w_state_nxt = S_OFF;
            end
         end
         S_UP: begin
            if (!r_blink_q) begin
               w_state_nxt = S_DOWN;
            end else if (w_tick) begin
               w_level_nxt = w_level_inc;
               if (w_level_inc == LVL_MAX) begin
                  w_state_nxt = S_ON;
               end else begin
                  w_state_nxt = S_UP;
               end
            end else begin
               w_state_nxt = S_UP;
            end
         end
         S_ON: begin
            if (!r_blink_q) begin
               w_state_nxt = S_DOWN;
            end else begin
               w_state_nxt = S_ON;
            end
         end
         S_DOWN: begin
            if (r_blink_q) begin
               w_state_nxt = S_UP;
            end else if (w_tick) begin
               w_level_nxt = w_level_dec;
               if (w_level_dec == LVL_ZERO) begin
                  w_state_nxt = S_OFF;
               end else begin
                  w_state_nxt = S_DOWN;
               end
            end else begin
               w_state_nxt = S_DOWN;
            end
         end
         default: begin
            w_state_nxt = S_OFF;
            w_level_nxt = LVL_ZERO;
         end
      endcase
   end

   // Input register, step divider, state/level and busy registers.
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         r_blink_q <= 1'b0;
         r_div_cnt <= DIV_ZERO;
         r_state   <= S_OFF;
         r_level   <= LVL_ZERO;
         r_busy    <= 1'b0;
      end else begin
         r_blink_q <= blink_i;
         if (w_boundary) begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? DIV_ZERO : (r_div_cnt + DIV_ONE);
         end
         r_state <= w_state_nxt;
         r_level <= w_level_nxt;
         r_busy  <= (w_state_nxt == S_UP) || (w_state_nxt == S_DOWN);
      end
   end

   blinker_pwm_gen #(
      .PWM_W (PWM_W)
   ) u_pwm (
      .i_clk      (system1000),
      .i_rst      (system1000_rst),
      .i_duty     (w_duty),
      .o_boundary (w_boundary),
      .o_led      (w_led)
   );

   assign led_o   = w_led;
   assign level_o = r_level;
   assign busy_o  = r_busy;

endmodule

// File: tb/tb_blinker_dimmer.sv
// Bench for blinker_dimmer: two instances (STEP_DIV 1 and 3, PWM_W 4) share
// clock, reset and blink input; a cycle-level behavioural model predicts every
// output each cycle, and directed phases pin the model with literal values.
module tb_blinker_dimmer;

   localparam int MAXV = 15;
`ifdef BLINKER_GAMMA_EN
   localparam int DUTY8 = 4;
`else
   localparam int DUTY8 = 8;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       blink;
   logic       led0, led1, busy0, busy1;
   logic [3:0] lvl0, lvl1;

   always #5 clk = ~clk;

   blinker_dimmer #(.PWM_W(4), .STEP_DIV(1)) dut0 (
      .system1000(clk), .system1000_rst(rst), .blink_i(blink),
      .led_o(led0), .level_o(lvl0), .busy_o(busy0));

   blinker_dimmer #(.PWM_W(4), .STEP_DIV(3)) dut1 (
      .system1000(clk), .system1000_rst(rst), .blink_i(blink),
      .led_o(led1), .level_o(lvl1), .busy_o(busy1));

   int checks   = 0;
   int failures = 0;

   // Model: cycles since reset, registered blink, and per instance the level,
   // ramp direction, whether the ramp has settled, period duty and LED.
   int sd[2] = '{1, 3};
   int t;
   bit bq;
   int m_level[2];
   bit m_dir[2];
   bit m_settled[2];
   int m_pduty[2];
   bit m_led[2];

   function automatic int duty_of(input int lvl);
`ifdef BLINKER_GAMMA_EN
      if (lvl == MAXV) return MAXV;
      return (lvl * lvl) / 16;
`else
      return lvl;
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model over the posedge just passed, using the inputs held across it.
   task automatic model_step();
      int p;
      int pd;
      bit tick;
      if (rst) begin
         t  = 0;
         bq = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_level[k] = 0; m_dir[k] = 1'b0; m_settled[k] = 1'b1;
            m_pduty[k] = 0; m_led[k] = 1'b0;
         end
      end else begin
         p = t % 16;
         for (int k = 0; k < 2; k++) begin
            pd = (p == 0) ? duty_of(m_level[k]) : m_pduty[k];
            m_pduty[k] = pd;
            m_led[k]   = (pd == MAXV) || (p < pd);
            tick = ((t % (16 * sd[k])) == 16 * (sd[k] - 1));
            if (bq != m_dir[k]) begin
               m_dir[k]     = bq;
               m_settled[k] = 1'b0;
            end else if (!m_settled[k] && tick) begin
               if (m_dir[k]) begin
                  m_level[k] = (m_level[k] < MAXV) ? m_level[k] + 1 : MAXV;
                  if (m_level[k] == MAXV) m_settled[k] = 1'b1;
               end else begin
                  m_level[k] = (m_level[k] > 0) ? m_level[k] - 1 : 0;
                  if (m_level[k] == 0) m_settled[k] = 1'b1;
               end
            end
         end
         bq = blink;
         t++;
      end
   endtask

   task automatic compare_all();
      check("led0",  int'(led0),  int'(m_led[0]));
      check("level0", int'(lvl0), m_level[0]);
      check("busy0", int'(busy0), int'(!m_settled[0]));
      check("led1",  int'(led1),  int'(m_led[1]));
      check("level1", int'(lvl1), m_level[1]);
      check("busy1", int'(busy1), int'(!m_settled[1]));
   endtask

   // One clock: wait for the falling edge, advance the model, compare.
   task automatic cycle();
      @(negedge clk);
      model_step();
      compare_all();
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int cnt;
      int hold;
      rst   = 1'b1;
      blink = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;

      // Quiet: blink low, everything dark.
      for (int n = 1; n <= 100; n++) begin
         cycle();
         check("quiet", {27'd0, led0, busy0, lvl0}, 0);
      end

      // Full ramp up with STEP_DIV 1, and STEP_DIV 3 alongside.
      reset_pulse();
      blink = 1'b1;
      cnt   = 0;
      for (int n = 1; n <= 300; n++) begin
         cycle();
         if (n == 1)   check("busy_not_yet", int'(busy0), 0);
         if (n == 2)   check("busy_rise", int'(busy0), 1);
         if (n == 80)  check("div3_lvl_a", int'(lvl1), 1);
         if (n == 81)  check("div3_lvl_b", int'(lvl1), 2);
         if (n == 128) check("div3_lvl_c", int'(lvl1), 2);
         if (n == 129) check("div3_lvl_d", int'(lvl1), 3);
         if (n == 144) check("led_before_period", int'(led0), 0);
         if (n == 145) check("led_period_start", int'(led0), 1);
         if (n >= 145 && n <= 160 && led0) cnt++;
         if (n == 161) check("duty8_high_count", cnt, DUTY8);
         if (n == 240) begin
            check("ramp_lvl14", int'(lvl0), 14);
            check("ramp_busy14", int'(busy0), 1);
         end
         if (n == 241) begin
            check("ramp_lvl15", int'(lvl0), 15);
            check("ramp_busy15", int'(busy0), 0);
         end
         if (n >= 258) check("full_on", int'(led0), 1);
      end

      // Ramp down from level 6.
      reset_pulse();
      blink = 1'b1;
      for (int n = 1; n <= 97; n++) cycle();
      check("up_lvl6", int'(lvl0), 6);
      blink = 1'b0;
      for (int n = 98; n <= 200; n++) begin
         cycle();
         if (n == 99)  check("down_keep6", int'(lvl0), 6);
         if (n == 112) check("down_still6", int'(lvl0), 6);
         if (n == 113) check("down_lvl5", int'(lvl0), 5);
         if (n == 192) check("down_lvl1", int'(lvl0), 1);
         if (n == 193) begin
            check("down_lvl0", int'(lvl0), 0);
            check("down_idle", int'(busy0), 0);
         end
      end

      // Reset mid-ramp at level 9, then restart with blink still high.
      reset_pulse();
      blink = 1'b1;
      for (int n = 1; n <= 145; n++) cycle();
      check("pre_reset_lvl9", int'(lvl0), 9);
      reset_pulse();
      check("rst_dark", {24'd0, led0, busy0, lvl0, led1, busy1}, 0);
      check("rst_lvl1", int'(lvl1), 0);
      cycle();
      check("restart_busy_n1", int'(busy0), 0);
      cycle();
      check("restart_busy_n2", int'(busy0), 1);
      check("restart_lvl", int'(lvl0), 0);

      // Random blink patterns with occasional reset pulses.
      for (int seg = 0; seg < 40; seg++) begin
         blink = 1'($urandom_range(0, 1));
         hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(20, 400);
         if ($urandom_range(0, 7) == 0) begin
            reset_pulse();
            check("rnd_rst_dark", {27'd0, led0, busy0, lvl0}, 0);
         end
         for (int i = 0; i < hold; i++) cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
